// File: rtl/audio_sample_reader.sv
// Streams 16-bit samples from a word-addressed memory into a small
// output FIFO that feeds the codec serializer.
module audio_sample_reader #(
   parameter int NUM_WORDS  = 2100000,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        stop,
   input  logic        loop_en,
   output logic [21:0] mem_address,
   output logic        mem_chipselect,
   output logic        mem_clken,
   input  logic [15:0] mem_readdata,
   output logic [15:0] sample_data,
   output logic        sample_valid,
   input  logic        sample_ready,
   output logic        busy,
   output logic        done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [21:0] LAST = 22'(NUM_WORDS - 1);
   localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } state_t;

   state_t        state;
   logic          inflight;
   logic [CW-1:0] fifo_count;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [15:0]   fifo_mem [FIFO_DEPTH];
   logic [CW:0]   occupancy;
   logic          issue;
   logic          abort;
   logic          push;
   logic          pop;

   // A read may only go out if its word is guaranteed a FIFO slot.
   assign occupancy = {1'b0, fifo_count}
                    + {{CW{1'b0}}, inflight};
   assign abort = stop && (state != IDLE);
   assign issue = (state == FETCH) && !stop
                && (occupancy < DEPTH_V);
   assign push  = inflight;
   assign pop   = sample_valid && sample_ready;

   assign mem_chipselect = issue;
   assign mem_clken      = reset_n;
   assign sample_valid   = (fifo_count != '0);
   assign sample_data    = sample_valid ? fifo_mem[rd_ptr] : '0;

   // Playback sequencing, address generation and status flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         mem_address <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state       <= IDLE;
            mem_address <= '0;
            busy        <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start && !stop) begin
                     state       <= FETCH;
                     mem_address <= '0;
                     busy        <= 1'b1;
                  end
               end
               FETCH: begin
                  if (issue) begin
                     if (mem_address == LAST) begin
                        mem_address <= '0;
                        if (!loop_en) state <= DRAIN;
                     end else begin
                        mem_address <= mem_address + 22'd1;
                     end
                  end
               end
               DRAIN: begin
                  if (!inflight && fifo_count == '0) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   // FIFO bookkeeping; abort drops buffered and in-flight words.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inflight   <= 1'b0;
         fifo_count <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
      end else if (abort) begin
         inflight   <= 1'b0;
         fifo_count <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
      end else begin
         inflight <= issue;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end

   // FIFO storage; contents are qualified by fifo_count, so no reset.
   always_ff @(posedge clk) begin
      if (push && !abort) fifo_mem[wr_ptr] <= mem_readdata;
   end

endmodule

// File: doc/audio_sample_reader.md
AUDIO_SAMPLE_READER -- requirements
Module: audio_sample_reader

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 2100000: number of 16-bit sample words in the sample memory.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: output buffer depth in words; power of two, 4 to 64.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk and reset_n.
REQ-004 clk  input  1  single clock, shared with the sample memory.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to begin playback from address 0.
REQ-007 stop  input  1  one-cycle abort request.
REQ-008 loop_en  input  1  when 1, wrap from NUM_WORDS-1 to 0; sampled on every address wrap.
REQ-009 mem_address  output  22  word address to the sample memory.
REQ-010 mem_chipselect  output  1  read strobe; one word is requested per asserted cycle.
REQ-011 mem_clken  output  1  memory clock enable; tied high while reset_n=1.
REQ-012 mem_readdata  input  16  memory data, valid exactly 1 cycle after the strobe.
REQ-013 sample_data  output  16  sample toward the codec serializer.
REQ-014 sample_valid  output  1  sample_data holds a valid sample.
REQ-015 sample_ready  input  1  consumer accepts the sample this cycle.
REQ-016 busy  output  1  high in FETCH or DRAIN.
REQ-017 done  output  1  one-cycle pulse when a non-looping playback completes.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, DRAIN.
- IDLE->FETCH on start.
- FETCH->DRAIN after the read of NUM_WORDS-1 is issued with loop_en=0.
- DRAIN->IDLE when no read is in flight and the FIFO is empty; done pulses in that same cycle.
REQ-019 SHALL issue a read (mem_chipselect=1) in FETCH only when fifo_count + inflight < FIFO_DEPTH, where inflight is 0 or 1.
REQ-020 SHALL write mem_readdata into the FIFO on the cycle after each issued read, unconditionally; the guard in REQ-019 prevents overflow.
REQ-021 SHALL increment mem_address by 1 after each issued read; at NUM_WORDS-1, the next address is 0 if loop_en=1, else the FSM enters DRAIN.
REQ-022 SHALL hold mem_address stable whenever mem_chipselect=0.
REQ-023 SHALL present the FIFO head on sample_data with sample_valid=(fifo_count!=0).
REQ-024 SHALL pop on sample_valid & sample_ready; sample_data SHALL stay stable while sample_valid & ~sample_ready.
REQ-025 SHALL support a simultaneous push and pop with fifo_count unchanged; a pop from an empty FIFO SHALL be ignored.
REQ-026 SHALL reach sustained throughput of one sample per cycle when sample_ready is held high.
- Latency from start to first sample_valid: 2 cycles (start seen, read issued, data pushed).
REQ-027 On stop in FETCH or DRAIN, SHALL in the next cycle go to IDLE, flush the FIFO, discard any in-flight read, and set mem_address=0; done SHALL NOT pulse.
REQ-028 SHALL ignore start while busy=1; start and stop in the same cycle SHALL resolve as stop.
REQ-029 SHALL ignore stop in IDLE.
REQ-030 SHALL have fifo_count width $clog2(FIFO_DEPTH)+1 and mem_address arithmetic modulo NUM_WORDS, never exceeding NUM_WORDS-1.

Reset
REQ-031 On reset_n=0, asynchronously: state=IDLE, mem_address=0, mem_chipselect=0, mem_clken=0, sample_valid=0, sample_data=0, busy=0, done=0, FIFO empty, inflight=0.
REQ-032 Reset mid-playback SHALL discard all buffered and in-flight data; after release, no read is issued until start.

Verification
REQ-033 NUM_WORDS=16, loop_en=0, sample_ready=1, memory word n=n -> samples 0..15 in order, done pulses once, then busy=0.
REQ-034 NUM_WORDS=16, loop_en=1, sample_ready=1 for 40 accepted samples -> sequence 0..15,0..15,0..7 with no gaps after the first sample.
REQ-035 FIFO_DEPTH=8, sample_ready=0 after start -> exactly 8 reads issued; mem_chipselect then 0, mem_address=8; sample_data=0 held stable.
REQ-036 stop in the cycle a read is in flight -> next cycle state IDLE, sample_valid=0, mem_address=0; the returning word is not pushed; no done.
REQ-037 start and stop asserted together in IDLE -> remains IDLE, mem_chipselect stays 0.
REQ-038 reset_n pulsed low mid-FETCH with 5 words buffered -> all outputs at reset values immediately; a new start replays from word 0.
